// File: rtl/dg_arbiter.sv
// DAG control-port arbiter: core has priority, DMA bursts fill the idle cycles.
// Define DG_ARB_STARVE_EN to build the starvation guard that forces DMA beats.
module dg_arbiter #(
    parameter int LEN_W      = 8,
    parameter int STARVE_W   = 3,
    parameter int STARVE_LIM = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ps_req,
    input  logic             ps_dgsclt,
    input  logic             ps_mdfy,
    input  logic [2:0]       ps_iadd,
    input  logic [2:0]       ps_madd,
    output logic             ps_gnt,
    output logic             ps_stall,
    input  logic             dma_start,
    input  logic             dma_dgsclt,
    input  logic             dma_mdfy,
    input  logic [2:0]       dma_iadd,
    input  logic [2:0]       dma_madd,
    input  logic [LEN_W-1:0] dma_len,
    output logic             dma_busy,
    output logic             dma_gnt,
    output logic             dma_done,
    output logic             arb_dg_en,
    output logic             arb_dg_dgsclt,
    output logic             arb_dg_mdfy,
    output logic [2:0]       arb_dg_iadd,
    output logic [2:0]       arb_dg_madd
);
    typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_beat_cnt;
    logic             r_dgsclt, r_mdfy, r_done;
    logic [2:0]       r_iadd, r_madd;
    logic             w_busy, w_ps_gnt, w_dma_gnt, w_accept, w_last;

    if (STARVE_LIM < 1 || STARVE_LIM >= (1 << STARVE_W)) begin : g_bad_lim
        $error("dg_arbiter: STARVE_LIM outside 1..2^STARVE_W-1");
    end

    assign w_busy = (r_state == ST_BURST);

`ifdef DG_ARB_STARVE_EN
    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);
    logic [STARVE_W-1:0] r_starve_cnt;

    // Core wins only while the pending burst has not been starved too long.
    assign w_ps_gnt = ps_req & (~w_busy | (r_starve_cnt < LIM));
    assign ps_stall = ps_req & ~w_ps_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_starve_cnt <= '0;
        else if (w_dma_gnt)
            r_starve_cnt <= '0;
        else if (w_busy && w_ps_gnt && r_starve_cnt < LIM)
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end
`else
    assign w_ps_gnt = ps_req;
    assign ps_stall = 1'b0;
`endif

    assign w_dma_gnt = w_busy & ~w_ps_gnt;
    assign w_accept  = ~w_busy & dma_start;
    assign w_last    = w_dma_gnt & (r_beat_cnt == LEN_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && dma_len != '0) w_state_nxt = ST_BURST;
            ST_BURST: if (w_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_dgsclt   <= 1'b0;
            r_mdfy     <= 1'b0;
            r_iadd     <= '0;
            r_madd     <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept && dma_len != '0) begin
                r_beat_cnt <= dma_len;
                r_dgsclt   <= dma_dgsclt;
                r_mdfy     <= dma_mdfy;
                r_iadd     <= dma_iadd;
                r_madd     <= dma_madd;
            end else if (w_dma_gnt) begin
                r_beat_cnt <= r_beat_cnt - 1'b1;
            end
            // Zero-length bursts complete immediately without entering BURST.
            r_done <= (w_accept && dma_len == '0) || w_last;
        end
    end

    always_comb begin
        arb_dg_en     = 1'b0;
        arb_dg_dgsclt = 1'b0;
        arb_dg_mdfy   = 1'b0;
        arb_dg_iadd   = '0;
        arb_dg_madd   = '0;
        if (w_ps_gnt) begin
            arb_dg_en     = 1'b1;
            arb_dg_dgsclt = ps_dgsclt;
            arb_dg_mdfy   = ps_mdfy;
            arb_dg_iadd   = ps_iadd;
            arb_dg_madd   = ps_madd;
        end else if (w_dma_gnt) begin
            arb_dg_en     = 1'b1;
            arb_dg_dgsclt = r_dgsclt;
            arb_dg_mdfy   = r_mdfy;
            arb_dg_iadd   = r_iadd;
            arb_dg_madd   = r_madd;
        end
    end

    assign ps_gnt   = w_ps_gnt;
    assign dma_gnt  = w_dma_gnt;
    assign dma_busy = w_busy;
    assign dma_done = r_done;
endmodule

// File: tb/tb_dg_arbiter.sv
// Directed bench for dg_arbiter; status vector is {ps_gnt,ps_stall,dma_gnt,dma_busy,dma_done},
// DAG bus vector is {en,dgsclt,mdfy,iadd,madd}.
module tb_dg_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps_req, ps_dgsclt, ps_mdfy;
    logic [2:0] ps_iadd, ps_madd;
    logic       ps_gnt, ps_stall;
    logic       dma_start, dma_dgsclt, dma_mdfy;
    logic [2:0] dma_iadd, dma_madd;
    logic [7:0] dma_len;
    logic       dma_busy, dma_gnt, dma_done;
    logic       arb_dg_en, arb_dg_dgsclt, arb_dg_mdfy;
    logic [2:0] arb_dg_iadd, arb_dg_madd;

    int errors = 0;
    int checks = 0;

    dg_arbiter #(.LEN_W(8), .STARVE_W(3), .STARVE_LIM(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ps_req(ps_req), .ps_dgsclt(ps_dgsclt), .ps_mdfy(ps_mdfy),
        .ps_iadd(ps_iadd), .ps_madd(ps_madd),
        .ps_gnt(ps_gnt), .ps_stall(ps_stall),
        .dma_start(dma_start), .dma_dgsclt(dma_dgsclt), .dma_mdfy(dma_mdfy),
        .dma_iadd(dma_iadd), .dma_madd(dma_madd), .dma_len(dma_len),
        .dma_busy(dma_busy), .dma_gnt(dma_gnt), .dma_done(dma_done),
        .arb_dg_en(arb_dg_en), .arb_dg_dgsclt(arb_dg_dgsclt), .arb_dg_mdfy(arb_dg_mdfy),
        .arb_dg_iadd(arb_dg_iadd), .arb_dg_madd(arb_dg_madd)
    );

    always #5 clk = ~clk;

    wire [4:0] st  = {ps_gnt, ps_stall, dma_gnt, dma_busy, dma_done};
    wire [8:0] bus = {arb_dg_en, arb_dg_dgsclt, arb_dg_mdfy, arb_dg_iadd, arb_dg_madd};

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ps_req = 0; ps_dgsclt = 0; ps_mdfy = 0; ps_iadd = 0; ps_madd = 0;
        dma_start = 0; dma_dgsclt = 0; dma_mdfy = 0; dma_iadd = 0; dma_madd = 0;
        dma_len = 0;
    endtask

    task automatic start_burst(input logic [7:0] len, input logic [2:0] ia, input logic [2:0] ma,
                               input logic sel, input logic mod);
        dma_start = 1; dma_len = len; dma_iadd = ia; dma_madd = ma;
        dma_dgsclt = sel; dma_mdfy = mod;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        checks++;
        if ({st, bus} !== 14'h0) begin
            errors++; $display("FAIL reset_hold: got st=%b bus=%b want 0", st, bus);
        end
        cyc(); cyc();
        rst_n = 1;
        cyc(); #2;
        checks++;
        if ({st, bus} !== 14'h0) begin
            errors++; $display("FAIL reset_idle: got st=%b bus=%b want 0", st, bus);
        end
        cyc();
    endtask

    task automatic test_burst_quiet();
        start_burst(8'd3, 3'd2, 3'd1, 1'b0, 1'b0);
        #2;
        checks++;
        if (st !== 5'b00000) begin
            errors++; $display("FAIL quiet_accept: got st=%b want 00000", st);
        end
        cyc();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (st !== 5'b00110 || bus !== 9'b100_010_001) begin
                errors++; $display("FAIL quiet_beat%0d: got st=%b bus=%b want 00110 100010001", i, st, bus);
            end
            cyc();
        end
        #2;
        checks++;
        if (st !== 5'b00001 || bus !== 9'h0) begin
            errors++; $display("FAIL quiet_done: got st=%b bus=%b want 00001 0", st, bus);
        end
        cyc(); #2;
        checks++;
        if (st !== 5'b00000) begin
            errors++; $display("FAIL quiet_after: got st=%b want 00000", st);
        end
        cyc();
    endtask

    task automatic test_core_priority();
        start_burst(8'd2, 3'd5, 3'd3, 1'b1, 1'b1);
        cyc();
        idle_inputs();
        ps_req = 1; ps_dgsclt = 0; ps_mdfy = 1; ps_iadd = 3'd7; ps_madd = 3'd6;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (st !== 5'b10010 || bus !== 9'b101_111_110) begin
                errors++; $display("FAIL prio_core%0d: got st=%b bus=%b want 10010 101111110", i, st, bus);
            end
            cyc();
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (st !== 5'b00110 || bus !== 9'b111_101_011) begin
                errors++; $display("FAIL prio_dma%0d: got st=%b bus=%b want 00110 111101011", i, st, bus);
            end
            cyc();
        end
        #2;
        checks++;
        if (st !== 5'b00001) begin
            errors++; $display("FAIL prio_done: got st=%b want 00001", st);
        end
        cyc();
    endtask

    task automatic test_starvation();
        logic [4:0] exp;
        ps_req = 1;
        start_burst(8'd2, 3'd1, 3'd1, 1'b0, 1'b0);
        #2;
        checks++;
        if (st !== 5'b10000) begin
            errors++; $display("FAIL starve_accept: got st=%b want 10000", st);
        end
        cyc();
        dma_start = 0;
`ifdef DG_ARB_STARVE_EN
        for (int c = 1; c <= 10; c++) begin
            exp = (c % 5 == 0) ? 5'b01110 : 5'b10010;
            #2;
            checks++;
            if (st !== exp) begin
                errors++; $display("FAIL starve_cyc%0d: got st=%b want %b", c, st, exp);
            end
            cyc();
        end
        #2;
        checks++;
        if (st !== 5'b10001) begin
            errors++; $display("FAIL starve_done: got st=%b want 10001", st);
        end
`else
        for (int c = 1; c <= 6; c++) begin
            exp = 5'b10010;
            #2;
            checks++;
            if (st !== exp) begin
                errors++; $display("FAIL strict_cyc%0d: got st=%b want %b", c, st, exp);
            end
            cyc();
        end
        ps_req = 0;
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++;
            if (st !== 5'b00110) begin
                errors++; $display("FAIL strict_beat%0d: got st=%b want 00110", c, st);
            end
            cyc();
        end
        #2;
        checks++;
        if (st !== 5'b00001) begin
            errors++; $display("FAIL strict_done: got st=%b want 00001", st);
        end
`endif
        idle_inputs();
        cyc();
    endtask

    task automatic test_len_zero();
        start_burst(8'd0, 3'd4, 3'd4, 1'b1, 1'b1);
        #2;
        checks++;
        if (st !== 5'b00000) begin
            errors++; $display("FAIL len0_accept: got st=%b want 00000", st);
        end
        cyc();
        idle_inputs();
        #2;
        checks++;
        if (st !== 5'b00001 || bus !== 9'h0) begin
            errors++; $display("FAIL len0_done: got st=%b bus=%b want 00001 0", st, bus);
        end
        cyc(); #2;
        checks++;
        if (st !== 5'b00000) begin
            errors++; $display("FAIL len0_after: got st=%b want 00000", st);
        end
        cyc();
    endtask

    task automatic test_start_ignored();
        start_burst(8'd2, 3'd4, 3'd2, 1'b0, 1'b0);
        cyc();
        start_burst(8'd9, 3'd1, 3'd7, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (st !== 5'b00110 || bus !== 9'b100_100_010) begin
                errors++; $display("FAIL ignore_beat%0d: got st=%b bus=%b want 00110 100100010", i, st, bus);
            end
            cyc();
            if (i == 0) idle_inputs();
        end
        #2;
        checks++;
        if (st !== 5'b00001) begin
            errors++; $display("FAIL ignore_done: got st=%b want 00001", st);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        start_burst(8'd5, 3'd3, 3'd1, 1'b0, 1'b0);
        cyc();
        idle_inputs();
        #2;
        checks++;
        if (st !== 5'b00110) begin
            errors++; $display("FAIL rmid_beat: got st=%b want 00110", st);
        end
        cyc();
        rst_n = 0;
        #1;
        checks++;
        if ({st, bus} !== 14'h0) begin
            errors++; $display("FAIL rmid_async: got st=%b bus=%b want 0", st, bus);
        end
        cyc();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            checks++;
            if (st !== 5'b00000) begin
                errors++; $display("FAIL rmid_quiet%0d: got st=%b want 00000", i, st);
            end
        end
        cyc();
        start_burst(8'd1, 3'd6, 3'd5, 1'b1, 1'b0);
        cyc();
        idle_inputs();
        #2;
        checks++;
        if (st !== 5'b00110 || bus !== 9'b110_110_101) begin
            errors++; $display("FAIL rmid_restart: got st=%b bus=%b want 00110 110110101", st, bus);
        end
        cyc(); #2;
        checks++;
        if (st !== 5'b00001) begin
            errors++; $display("FAIL rmid_done: got st=%b want 00001", st);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_burst_quiet();
        test_core_priority();
        test_starvation();
        test_len_zero();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dg_arbiter.md
# dg_arbiter

Arbiter and burst sequencer for the data address generator's single control port. It shares the port between the program sequencer (core, priority requester) and a DMA block-move engine that issues bursts of post-modify accesses through one I/M register pair. It drives the DAG enable, select, modify and index controls each cycle and stalls whichever requester loses. A starvation guard bounds how long core traffic can block a pending DMA burst.

## Interface
- LEN_W, 8, width of DMA burst length and beat counter
- STARVE_W, 3, width of starvation counter
- STARVE_LIM, 4, consecutive lost DMA cycles before a forced DMA beat; legal range 1..2^STARVE_W-1
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ps_req  in  1  core requests a DAG access this cycle
- ps_dgsclt, ps_mdfy  in  1 each  core DAG select (0 = DM, 1 = PM) and pre-modify
- ps_iadd, ps_madd  in  3 each  core I and M register index
- ps_gnt  out  1  core access driven to the DAG this cycle
- ps_stall  out  1  ps_req & ~ps_gnt
- dma_start  in  1  start a burst; accepted only when dma_busy=0
- dma_dgsclt, dma_mdfy  in  1 each  burst select and modify, latched at accept
- dma_iadd, dma_madd  in  3 each  burst I and M index, latched at accept
- dma_len  in  LEN_W  burst beat count, latched at accept
- dma_busy  out  1  burst pending
- dma_gnt  out  1  one DMA beat driven to the DAG this cycle
- dma_done  out  1  one-cycle pulse after the final beat
- arb_dg_en, arb_dg_dgsclt, arb_dg_mdfy  out  1 each  to DAG en, dgsclt, mdfy
- arb_dg_iadd, arb_dg_madd  out  3 each  to DAG iadd, madd

## Operation
- States: IDLE and BURST.
- IDLE behaviour:
  - dma_start with dma_len≠0 latches the dgsclt, mdfy, iadd and madd fields, sets beat_cnt=dma_len and moves to BURST.
  - dma_start with dma_len=0 stays in IDLE and pulses dma_done on the next cycle.
  - No DMA beat is granted in the accept cycle.
- BURST behaviour:
  - DMA is pending every cycle.
  - Per-cycle arbitration: if ps_req=1 and starve_cnt<STARVE_LIM, the core wins. Otherwise DMA wins.
  - On each dma_gnt, beat_cnt decrements and starve_cnt clears.
  - When a core win blocks DMA, starve_cnt increments; it saturates at STARVE_LIM.
  - A dma_gnt with beat_cnt=1 returns to IDLE and sets dma_done for the following cycle.
- dma_start is ignored while dma_busy=1.
- Output mux (combinational):
  - ps_gnt=1: arb_dg_* = core fields, arb_dg_en=1.
  - dma_gnt=1: arb_dg_* = latched burst fields, arb_dg_en=1.
  - Otherwise all arb_dg_* = 0.
- ps_gnt and dma_gnt are never both 1.
- The DAG post-modifies I on the clock edge when arb_dg_en=1 and mdfy=0. A burst with mdfy=0 therefore walks I by M once per beat.
- dma_busy = (state==BURST).

## Timing
- Reset values: state=IDLE, beat_cnt=0, starve_cnt=0, latched fields=0, dma_done=0. All outputs are 0.
- ps_gnt, dma_gnt, ps_stall and arb_dg_* are combinational from ps_req and registered state. Zero-cycle grant latency.
- The first DMA beat can occur one cycle after dma_start is accepted.
- dma_done is registered and asserts exactly one cycle after the final dma_gnt.
- When ps_req is low throughout, a burst of N beats occupies N consecutive cycles.
- With constant ps_req and the guard compiled in, DMA receives 1 beat per STARVE_LIM+1 cycles.
- Reset asserted mid-burst: immediate return to IDLE, counters cleared, no dma_done. Grants drop asynchronously.
- Core stalled on a forced beat: ps_stall=1 for exactly that cycle. starve_cnt=0 the next cycle.

## Configuration
- DG_ARB_STARVE_EN defined: the starvation guard operates as described above.
- DG_ARB_STARVE_EN not defined:
  - Strict core priority; starve_cnt is not built.
  - DMA beats occur only in cycles with ps_req=0.
  - ps_stall is constant 0.

## Test plan
- Reset then idle:
  - Stimulus: release rst_n, drive no requests.
  - Required: all outputs 0, dma_busy=0.
- DMA burst, core quiet:
  - Stimulus: dma_start, len=3, iadd=2, madd=1, dgsclt=0, mdfy=0.
  - Required: dma_gnt for 3 consecutive cycles starting 1 cycle after accept, arb_dg_iadd=2 and arb_dg_madd=1 on each beat, dma_done on the 4th cycle, dma_busy then 0.
- Core priority within limit:
  - Stimulus: burst len=2, ps_req=1 for 2 cycles at burst start, STARVE_LIM=4.
  - Required: ps_gnt for 2 cycles, then 2 dma_gnt, ps_stall=0 throughout.
- Starvation guard:
  - Stimulus: DG_ARB_STARVE_EN defined, STARVE_LIM=4, ps_req held 1, burst len=2.
  - Required: pattern of 4 ps_gnt then 1 dma_gnt with ps_stall=1, repeated; dma_done after the 10th burst cycle.
- Edge cases:
  - dma_len=0: dma_done pulse next cycle, dma_busy stays 0.
  - dma_start during BURST: ignored, latched fields unchanged.
- Reset mid-burst:
  - Stimulus: assert rst_n low after the 1st beat of a len=5 burst.
  - Required: dma_busy=0 and dma_gnt=0 immediately, no dma_done, next dma_start accepted normally.
